btn_debounce_fsm: RTL and testbench
===================================

Name: btn_debounce_fsm

Overview:
- Consumes the slow sampling tick from the board clock divider and turns a raw, bouncy push-button into clean signals for the Tamagotchi control logic.
- Runs entirely in the fast clock domain. The tick is used as a clock enable, never as a clock.
- Outputs a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse.
- One instance per button.

Parameters:
ACTIVE_LOW, 1, 1 = button reads 0 when pressed; 0 = reads 1 when pressed
STABLE_TICKS, 4, consecutive identical tick samples needed to accept a level change; legal range 2..255
LONG_TICKS, 8, ticks in qualified PRESSED state before long_pulse fires; legal range 1..255

Ports:
clk_in  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous, active-low reset
tick  input  1  one-clk_in-cycle sampling enable from the divider; tied high is legal and samples every cycle
btn_raw  input  1  raw button pin, asynchronous to clk_in
btn_level  output  1  debounced level, 1 = pressed
press_pulse  output  1  high for 1 clk_in cycle on a qualified press
release_pulse  output  1  high for 1 clk_in cycle on a qualified release
long_pulse  output  1  high for 1 clk_in cycle, once per press, when the hold time reaches LONG_TICKS

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE; stab_cnt = 0; hold_cnt = 0.
  - btn_level, press_pulse, release_pulse and long_pulse all 0.
  - Both synchronizer flops load the inactive pin level (ACTIVE_LOW).
- Synchronizer: 2 flops on btn_raw, clocked every clk_in cycle regardless of tick.
- Normalized sample: p = sync2 XOR ACTIVE_LOW, so p = 1 means pressed.
- FSM and counters change only on cycles with tick=1. With tick=0 all state holds and all pulse outputs are 0.
- All outputs are registered. A pulse appears in the clk_in cycle after the qualifying tick cycle and lasts exactly 1 cycle.
- Counter widths: stab_cnt and hold_cnt are 8 bits. hold_cnt saturates at LONG_TICKS.
- States (one transition per tick):
  - IDLE (btn_level=0):
    - p=1 -> PRESS_CHK, stab_cnt=1.
    - p=0 -> stay.
  - PRESS_CHK:
    - p=1 and stab_cnt+1 == STABLE_TICKS -> PRESSED; btn_level=1; press_pulse; hold_cnt=0; stab_cnt=0.
    - p=1 otherwise -> stab_cnt+1.
    - p=0 -> IDLE, stab_cnt=0, no pulse.
  - PRESSED:
    - p=1 -> hold_cnt+1 (saturating). On the tick where hold_cnt becomes LONG_TICKS, assert long_pulse. No further long_pulse for this press.
    - p=0 -> RELEASE_CHK, stab_cnt=1. hold_cnt is kept.
  - RELEASE_CHK (btn_level stays 1):
    - p=0 and stab_cnt+1 == STABLE_TICKS -> IDLE; btn_level=0; release_pulse; hold_cnt=0; stab_cnt=0.
    - p=0 otherwise -> stab_cnt+1.
    - p=1 -> PRESSED, stab_cnt=0. hold_cnt resumes without increment on this tick, so a bounce does not restart or advance the long timer.
- Press latency: press_pulse fires one cycle after the STABLE_TICKS-th consecutive tick that sees p=1. Release latency is symmetric.
- press_pulse and long_pulse are never high in the same cycle. At most one of the three pulses is high in any cycle.
- Reset mid-operation:
  - All outputs clear immediately, with no release_pulse.
  - If the button is still held after reset deasserts, the press must re-qualify through PRESS_CHK and produces a new press_pulse.
- Tick tied high: the debounce window is STABLE_TICKS clk_in cycles. Behaviour is otherwise identical.

Test Plan:
Common bench setup: ACTIVE_LOW=1, STABLE_TICKS=4, LONG_TICKS=8, tick = 1 cycle every 10 clk_in cycles.
1. Reset idle: rst_n low 5 cycles, then btn_raw=1 for 200 cycles -> all outputs 0 throughout.
2. Clean press: btn_raw falls to 0 and holds -> exactly one press_pulse, 1 cycle wide, one cycle after the 4th tick that sees the synchronized 0; btn_level=1 from that cycle.
3. Bounce: btn_raw toggles every 3 cycles for 60 cycles, then settles at 0 -> no pulse during the bounce; exactly one press_pulse 4 ticks after settling.
4. Glitch: btn_raw=0 for 25 cycles (spans at most 3 ticks), then 1 -> no pulses; btn_level stays 0.
5. Long press and release:
   - Hold for 12 ticks after qualification -> one long_pulse on the 8th tick in PRESSED, and no repeat.
   - Then btn_raw=1 -> release_pulse 4 ticks later; btn_level=0.
   - A 1-tick re-press during RELEASE_CHK delays release and produces no extra pulses.
6. Reset mid-hold: assert rst_n while btn_level=1 -> outputs 0 asynchronously. Release rst_n with the button still held -> new press_pulse after 4 ticks; no release_pulse at any point.

Source files
------------

// File: rtl/btn_debounce_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_fsm_if
// Description : Tick/button inputs and debounced outputs of one button channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_debounce_fsm_if;
  logic tick;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output tick,
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  tick,
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_fsm
// Description : Tick-enabled push-button debouncer with press, release and
//               one-shot long-press pulses. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_fsm #(
  parameter logic ACTIVE_LOW   = 1'b1,
  parameter int   STABLE_TICKS = 4,
  parameter int   LONG_TICKS   = 8
) (
  input  wire logic        clk_in,
  input  wire logic        rst_n,
  btn_debounce_fsm_if.slave bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_TICKS);
  localparam logic [7:0] c_LONG   = 8'(LONG_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  logic       r_sync1;
  logic       r_sync2;
  state_t     r_state;
  logic [7:0] r_stab_cnt;
  logic [7:0] r_hold_cnt;
  logic       r_level;
  logic       r_press;
  logic       r_release;
  logic       r_long;

  state_t     w_state_nxt;
  logic [7:0] w_stab_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_level_nxt;
  logic       w_press_nxt;
  logic       w_release_nxt;
  logic       w_long_nxt;
  logic       w_p;

  // Normalised so that 1 always means "pressed", whatever the pin polarity.
  assign w_p = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= ACTIVE_LOW;
      r_sync2    <= ACTIVE_LOW;
      r_state    <= ST_IDLE;
      r_stab_cnt <= 8'd0;
      r_hold_cnt <= 8'd0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_sync1    <= bus.btn_raw;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_level    <= w_level_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_long     <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_stab_nxt    = r_stab_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;

    if (bus.tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_p) begin
            w_state_nxt = ST_PRESS_CHK;
            w_stab_nxt  = 8'd1;
          end
        end
        ST_PRESS_CHK: begin
          if (!w_p) begin
            w_state_nxt = ST_IDLE;
            w_stab_nxt  = 8'd0;
          end else if ((r_stab_cnt + 8'd1) == c_STABLE) begin
            w_state_nxt = ST_PRESSED;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_hold_nxt  = 8'd0;
            w_stab_nxt  = 8'd0;
          end else begin
            w_stab_nxt  = r_stab_cnt + 8'd1;
          end
        end
        ST_PRESSED: begin
          if (!w_p) begin
            w_state_nxt = ST_RELEASE_CHK;
            w_stab_nxt  = 8'd1;
          end else if (r_hold_cnt < c_LONG) begin
            // Saturation at c_LONG makes the long pulse one-shot per press.
            w_hold_nxt = r_hold_cnt + 8'd1;
            w_long_nxt = ((r_hold_cnt + 8'd1) == c_LONG);
          end
        end
        ST_RELEASE_CHK: begin
          if (w_p) begin
            // Bounce back: hold timer neither restarts nor advances.
            w_state_nxt = ST_PRESSED;
            w_stab_nxt  = 8'd0;
          end else if ((r_stab_cnt + 8'd1) == c_STABLE) begin
            w_state_nxt   = ST_IDLE;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
            w_hold_nxt    = 8'd0;
            w_stab_nxt    = 8'd0;
          end else begin
            w_stab_nxt    = r_stab_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_stab_nxt  = 8'd0;
          w_hold_nxt  = 8'd0;
          w_level_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level     = r_level;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.long_pulse    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce_fsm
// Description : Self-checking bench: per-cycle reference model scoreboard plus
//               table-driven press-length scenarios and reset/bounce sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_debounce_fsm;

  localparam int c_STABLE = 4;
  localparam int c_LONG   = 8;
  localparam int c_TPER   = 10;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  btn_debounce_fsm_if bus ();

  btn_debounce_fsm #(
    .ACTIVE_LOW   (1'b1),
    .STABLE_TICKS (c_STABLE),
    .LONG_TICKS   (c_LONG)
  ) u_dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } exp_t;

  typedef struct {
    string name;
    int    low_cycles;
    int    exp_press;
    int    exp_long;
    int    exp_rel;
  } vec_t;

  exp_t q_exp[$];
  int   tests    = 0;
  int   failures = 0;
  int   tick_cnt = 0;
  int   n_press, n_rel, n_long;

  // Reference model: counts consecutive ticks disagreeing with the accepted level.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_level = 1'b0;
  int   m_run = 0, m_hold = 0;
  logic m_press, m_rel, m_lng;

  task automatic model_edge();
    logic p;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
      m_run = 0; m_hold = 0;
      m_press = 0; m_rel = 0; m_lng = 0;
    end else begin
      p = ~m_s2;
      m_press = 0; m_rel = 0; m_lng = 0;
      if (bus.tick) begin
        if (p != m_level) begin
          m_run++;
          if (m_run == c_STABLE) begin
            m_level = p;
            m_run   = 0;
            m_hold  = 0;
            if (p) m_press = 1; else m_rel = 1;
          end
        end else begin
          if (m_level && m_run == 0 && m_hold < c_LONG) begin
            m_hold++;
            if (m_hold == c_LONG) m_lng = 1;
          end
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
    end
  endtask

  task automatic check(string name, int actual, int required);
    tests++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, required);
    end
  endtask

  task automatic step(logic btn);
    exp_t e, a;
    @(negedge clk_in);
    bus.btn_raw = btn;
    bus.tick    = (tick_cnt == c_TPER - 1);
    tick_cnt    = (tick_cnt == c_TPER - 1) ? 0 : tick_cnt + 1;
    model_edge();
    q_exp.push_back('{level: m_level, press: m_press, rel: m_rel, lng: m_lng});
    @(posedge clk_in);
    #1;
    a = '{level: bus.btn_level, press: bus.press_pulse,
          rel: bus.release_pulse, lng: bus.long_pulse};
    e = q_exp.pop_front();
    tests++;
    if (a != e) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t: got {lvl,prs,rel,lng}=%b expected %b",
               $time, a, e);
    end
    if (a.press) n_press++;
    if (a.rel)   n_rel++;
    if (a.lng)   n_long++;
  endtask

  task automatic run(logic btn, int cycles);
    for (int i = 0; i < cycles; i++) step(btn);
  endtask

  task automatic clr_counts();
    n_press = 0; n_rel = 0; n_long = 0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"glitch_25",  25, 0, 0, 0};
    vecs[1] = '{"press_45",   45, 1, 0, 1};
    vecs[2] = '{"press_100", 100, 1, 0, 1};
    vecs[3] = '{"press_110", 110, 1, 0, 1};
    vecs[4] = '{"press_150", 150, 1, 1, 1};
    vecs[5] = '{"press_200", 200, 1, 1, 1};

    bus.btn_raw = 1'b1;
    bus.tick    = 1'b0;
    rst_n       = 1'b0;

    // Reset and idle
    clr_counts();
    run(1'b1, 5);
    check("reset_level", int'(bus.btn_level), 0);
    rst_n = 1'b1;
    run(1'b1, 200);
    check("idle_press", n_press, 0);
    check("idle_rel",   n_rel,   0);
    check("idle_long",  n_long,  0);

    // Clean press then release
    clr_counts();
    run(1'b0, 100);
    check("clean_press", n_press, 1);
    check("clean_level", int'(bus.btn_level), 1);
    run(1'b1, 100);
    check("clean_rel",   n_rel, 1);
    check("clean_level_off", int'(bus.btn_level), 0);

    // Bounce, then settle pressed
    clr_counts();
    for (int i = 0; i < 20; i++) run(i[0], 3);
    check("bounce_no_press", n_press, 0);
    check("bounce_no_rel",   n_rel,   0);
    run(1'b0, 100);
    check("bounce_settle_press", n_press, 1);
    run(1'b1, 100);
    check("bounce_settle_rel", n_rel, 1);

    // Table-driven press lengths
    foreach (vecs[k]) begin
      clr_counts();
      run(1'b0, vecs[k].low_cycles);
      run(1'b1, 100);
      check({vecs[k].name, "_press"}, n_press, vecs[k].exp_press);
      check({vecs[k].name, "_long"},  n_long,  vecs[k].exp_long);
      check({vecs[k].name, "_rel"},   n_rel,   vecs[k].exp_rel);
      check({vecs[k].name, "_level"}, int'(bus.btn_level), 0);
    end

    // Long press, then a one-tick re-press inside the release window
    clr_counts();
    run(1'b0, 160);
    check("long_press", n_press, 1);
    check("long_once",  n_long,  1);
    run(1'b1, 20);
    run(1'b0, 10);
    check("repress_level_held", int'(bus.btn_level), 1);
    check("repress_no_rel", n_rel, 0);
    run(1'b1, 100);
    check("repress_press", n_press, 1);
    check("repress_long",  n_long,  1);
    check("repress_rel",   n_rel,   1);

    // Asynchronous reset while held
    clr_counts();
    run(1'b0, 60);
    check("rst_hold_level", int'(bus.btn_level), 1);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level", int'(bus.btn_level), 0);
    check("rst_async_pulses",
          int'({bus.press_pulse, bus.release_pulse, bus.long_pulse}), 0);
    run(1'b0, 3);
    rst_n = 1'b1;
    clr_counts();
    run(1'b0, 80);
    check("rst_requalify_press", n_press, 1);
    check("rst_no_rel", n_rel, 0);
    run(1'b1, 100);
    check("rst_final_rel", n_rel, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
